// File: rtl/demux_hold_pkg.sv
// demux_hold_pkg: default sizes and helpers shared by the demux_hold slice
package demux_hold_pkg;
  localparam int WIDTH = 16;
  localparam int NOUT = 4;
  localparam int SELW = 2;
  localparam int CNTW = 8;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with valid flag
module demux_slot #(
  parameter int WIDTH = demux_hold_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             consume,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  // a load in the same cycle as a consume keeps the slot full with the new word
  always_comb begin
    data_d  = load ? d : data_q;
    valid_d = load | (valid_q & ~consume);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  assign data  = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/demux_hold.sv
// demux_hold: registered 1-to-NOUT demux with per-channel valid/ready holding slots
module demux_hold
  import demux_hold_pkg::*;
#(
  parameter int WIDTH = demux_hold_pkg::WIDTH,
  parameter int NOUT  = demux_hold_pkg::NOUT,
  parameter int SELW  = demux_hold_pkg::SELW,
  parameter int CNTW  = demux_hold_pkg::CNTW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic [CNTW-1:0]       xfer_count
);
  if (SELW != clog2(NOUT)) begin : g_bad_selw
    $error("demux_hold: SELW must equal log2(NOUT)");
  end
  logic            acc;
  logic [NOUT-1:0] load;
  logic [CNTW-1:0] cnt_d, cnt_q;
  always_comb begin
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    acc      = in_valid & in_ready;
    load     = {NOUT{acc}} & (NOUT'(1) << in_sel);
    cnt_d    = cnt_q + CNTW'(acc);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign xfer_count = cnt_q;
  for (genvar i = 0; i < NOUT; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load[i]),
      .consume(out_ready[i]),
      .d      (in_data),
      .data   (out_data[i*WIDTH +: WIDTH]),
      .valid  (out_valid[i])
    );
  end
endmodule

// File: tb/tb_demux_hold.sv
// tb_demux_hold: directed + random check of demux_hold against a per-channel queue model
module tb_demux_hold;
  localparam int W = 16, N = 4, S = 2, C = 8;
  logic           clk = 0, rst = 1;
  logic [W-1:0]   in_data = '0;
  logic [S-1:0]   in_sel = '0;
  logic           in_valid = 0;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic [C-1:0]   xfer_count;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] q [N][$];
  logic [W-1:0] last [N];
  int cnt;

  demux_hold dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      q[c].delete();
      last[c] = '0;
    end
    cnt = 0;
  endtask

  function automatic logic m_ready();
    return q[in_sel].size() == 0 || out_ready[in_sel];
  endfunction

  function automatic logic [N-1:0] m_valid();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = q[c].size() != 0;
    return v;
  endfunction

  function automatic logic [N*W-1:0] m_data();
    logic [N*W-1:0] d;
    for (int c = 0; c < N; c++) d[c*W +: W] = last[c];
    return d;
  endfunction

  task automatic drive(input logic v, input int sel, input logic [W-1:0] d, input logic [N-1:0] rdy);
    in_valid = v;
    in_sel = S'(sel);
    in_data = d;
    out_ready = rdy;
  endtask

  // checks all outputs against the model, then advances one clock edge
  task automatic cycle();
    logic acc;
    #1;
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_valid()));
    chk("out_data", 64'(out_data), 64'(m_data()));
    chk("xfer_count", 64'(xfer_count), 64'(cnt));
    acc = in_valid && m_ready();
    @(posedge clk);
    for (int c = 0; c < N; c++)
      if (q[c].size() != 0 && out_ready[c]) void'(q[c].pop_front());
    if (acc) begin
      q[in_sel].push_back(in_data);
      last[in_sel] = in_data;
      cnt = (cnt + 1) % 256;
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [S-1:0] rs;
    logic rv;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_count", 64'(xfer_count), 64'h0);
    rst = 0;
    // basic routing
    drive(1, 2, 16'hA5A5, 4'b1111); cycle();
    chk("route2_valid", 64'(out_valid), 64'b0100);
    chk("route2_data", 64'(out_data[2*W +: W]), 64'hA5A5);
    drive(1, 0, 16'h1234, 4'b1111); cycle();
    chk("route0_valid", 64'(out_valid), 64'b0001);
    chk("route0_count", 64'(xfer_count), 64'd2);
    // backpressure on channel 1
    drive(1, 1, 16'h0001, 4'b1101); cycle();
    chk("bp_slot1", 64'(out_data[W +: W]), 64'h0001);
    drive(1, 1, 16'h0002, 4'b1101);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_ready", 64'(in_ready), 64'h0);
      chk("bp_hold", 64'(out_data[W +: W]), 64'h0001);
    end
    drive(1, 3, 16'h0003, 4'b0101); cycle();
    chk("bp_ch3", 64'(out_data[3*W +: W]), 64'h0003);
    chk("bp_ch1_still", 64'(out_valid[1]), 64'h1);
    // same-cycle refill on channel 1
    drive(1, 1, 16'hBEEF, 4'b1111);
    #1 chk("refill_ready", 64'(in_ready), 64'h1);
    cycle();
    chk("refill_valid", 64'(out_valid[1]), 64'h1);
    chk("refill_data", 64'(out_data[W +: W]), 64'hBEEF);
    // asynchronous reset with every channel loaded
    for (int c = 0; c < N; c++) begin
      drive(1, c, W'(16'h1000 + c), 4'b0000); cycle();
    end
    chk("full_valid", 64'(out_valid), 64'hF);
    drive(0, 0, '0, 4'b0000);
    #2 rst = 1;
    #1;
    chk("async_valid", 64'(out_valid), 64'h0);
    chk("async_data", 64'(out_data), 64'h0);
    chk("async_count", 64'(xfer_count), 64'h0);
    m_reset();
    @(posedge clk);
    #3 rst = 0;
    // counter wrap
    for (int k = 0; k < 256; k++) begin
      drive(1, $urandom_range(0, N - 1), W'($urandom), 4'b1111); cycle();
    end
    chk("wrap_zero", 64'(xfer_count), 64'h0);
    drive(1, 1, 16'h5555, 4'b1111); cycle();
    chk("wrap_one", 64'(xfer_count), 64'h1);
    // random soak; a stalled word is held until accepted
    rv = 1; rs = 0; rd = 16'h0;
    for (int k = 0; k < 10000; k++) begin
      if (!(rv && !m_ready())) begin
        rv = ($urandom_range(0, 3) != 0);
        rs = S'($urandom);
        rd = W'($urandom);
      end
      drive(rv, rs, rd, N'($urandom));
      cycle();
    end
    drive(0, 0, '0, 4'b1111); cycle(); cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_hold.md
Name: demux_hold

Overview:
- Registered 1-to-NOUT demultiplexer: the distributing counterpart of the team's 2:1 select mux.
- Routes one input word per accepted transfer to one of NOUT output channels, chosen by in_sel.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Used to steer CORDIC datapath results (x, y, z, status) to independent consumers, each of which can apply backpressure without affecting the other channels.

Parameters:
- WIDTH, 16, data word width in bits.
- NOUT, 4, number of output channels (power of two, >= 2).
- SELW, 2, select width; must equal log2(NOUT).
- CNTW, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  SELW  destination channel index.
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  block can accept this cycle (combinational).
- out_data  output  NOUT*WIDTH  flattened holding registers; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  NOUT  channel i holds an unconsumed word.
- out_ready  input  NOUT  consumer i takes its word this cycle.
- xfer_count  output  CNTW  number of accepted input transfers, modulo 2^CNTW.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: out_valid=0, all out_data=0, xfer_count=0. Everything else is synchronous to the rising edge of clk.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - This is a pure combinational function of current state, in_sel and out_ready; it does not depend on in_valid.
- Accept: the transfer is accepted when in_valid & in_ready at a clock edge.
  - On accept, slot[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - Latency is 1 cycle: the word is visible on out_data/out_valid in the cycle after acceptance.
- Consume: channel i is consumed when out_valid[i] & out_ready[i] at an edge.
  - On consume, out_valid[i] <= 0 unless an accept targets i in the same cycle.
- Simultaneous consume and accept on the same channel: the new word replaces the old one and out_valid[i] stays 1. Full throughput is one word per cycle per channel with no bubble.
- Full channel, no consume (out_valid[i]=1, out_ready[i]=0, in_sel=i):
  - in_ready=0, the word is not accepted.
  - slot[i] and out_valid[i] are unchanged.
  - Upstream must hold in_data/in_sel stable.
- Other channels are unaffected by an accept or consume on channel i. A full channel blocks only input words that target it.
- out_data[i] holds its last value after consumption; it is never cleared except by reset.
- out_ready[i] while out_valid[i]=0 has no effect.
- xfer_count increments by 1 on each accept and wraps from 2^CNTW-1 to 0. Consumes do not change it.
- in_valid=0: no state change except consumes.
- Reset asserted mid-operation: all held words are discarded immediately and out_valid drops asynchronously. The first edge after deassertion behaves as from the reset state.

Decomposition:
- Shared package holds:
  - the default constants WIDTH, NOUT, SELW, CNTW;
  - a function clog2 used to check that SELW equals log2(NOUT).
- Sub-module demux_slot: one WIDTH-bit holding register plus its valid flag, with load/consume inputs and the same clk/rst. demux_hold instantiates it NOUT times.
- The top level contains the select decode, the in_ready mux and the counter.

Test Plan:
- Reset: with rst=1 mid-stream after loading all channels -> out_valid=4'b0000, out_data=0, xfer_count=0 immediately, without waiting for a clock edge.
- Basic routing, all out_ready=1: send in_data=16'hA5A5 sel=2 -> next cycle out_valid=4'b0100 and slot2=16'hA5A5. Then sel=0 data 16'h1234 -> out_valid=4'b0001, xfer_count=2.
- Backpressure on channel 1:
  - out_ready[1]=0; send 16'h0001 to sel=1 -> accepted.
  - Send 16'h0002 to sel=1 -> in_ready=0; slot1 stays 16'h0001 over 5 cycles.
  - Meanwhile sel=3 data 16'h0003 is accepted while sel=1 is still stalled.
- Same-cycle refill: slot1 full with out_ready[1]=1 and in_valid=1 sel=1 data 16'hBEEF -> in_ready=1, out_valid[1] stays 1, slot1=16'hBEEF, one word consumed.
- Counter wrap: 256 back-to-back accepts with CNTW=8 -> xfer_count returns to 0; 257th accept -> 1.
- Random soak: 10k cycles of random in_valid/in_sel/out_ready checked against a per-channel scoreboard -> no loss, no duplication, and in-order delivery per channel.
